// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier feeding one partial add per cycle into a 16-bit RCA.
// Optional early termination when the remaining multiplier bits are zero: define SHIFT_ADD_MULT8_EARLY_TERM_EN.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module rca16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carryInput,
    output logic [15:0] sum,
    output logic        carryOutput
);
    logic [16:0] c;

    assign c[0] = carryInput;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        full_adder u_fa (
            .x   (a[i]),
            .y   (b[i]),
            .cin (c[i]),
            .s   (sum[i]),
            .cout(c[i+1])
        );
    end

    assign carryOutput = c[16];
endmodule

module shift_add_mult8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [3:0]  count;
    logic [15:0] acc;
    logic [15:0] sum;
    logic [15:0] acc_nxt;
    logic        accept;
    logic        finish;
    // Product of two 8-bit operands never exceeds 16 bits, so the carry is always 0.
    logic        carry_unused;

    rca16 u_rca (
        .a          (acc),
        .b          (mcand),
        .carryInput (1'b0),
        .sum        (sum),
        .carryOutput(carry_unused)
    );

    assign accept  = start && (state != CALC);
    assign acc_nxt = mplier[0] ? sum : acc;

`ifdef SHIFT_ADD_MULT8_EARLY_TERM_EN
    assign finish = (state == CALC) && ((mplier[7:1] == 7'd0) || (count == 4'd7));
`else
    assign finish = (state == CALC) && (count == 4'd7);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (finish) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            acc     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= {8'b0, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (state == CALC) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 4'd1;
            // product only moves on entry to DONE; partial sums stay internal.
            if (finish) product <= acc_nxt;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);
endmodule

// File: doc/shift_add_mult8.md
Name: shift_add_mult8

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier producing a 16-bit product.
- Sits directly upstream of the 16-bit ripple-carry adder (RCA16). It holds the multiplicand, multiplier and partial-product registers, and feeds one partial add per cycle into a single RCA16 instance.
- Registers the adder's sum back each cycle. Intended as the datapath controller for the team's multiply unit.

Parameters:
- None. Operand width is fixed at 8 bits and product width at 16 bits, to match the 16-bit adder.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a multiply; sampled on the rising edge of clk.
- a  input  8  multiplicand, unsigned; sampled with start.
- b  input  8  multiplier, unsigned; sampled with start.
- product  output  16  result register; holds the last completed product.
- busy  output  1  high while a multiply is in progress.
- done  output  1  single-cycle pulse marking that product is valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n is low:
  - state is IDLE.
  - product, busy and done are 0.
  - Internal registers (mcand 16b, mplier 8b, count 4b) are 0.
- States: IDLE, CALC, DONE.
- Accepting start:
  - In IDLE or DONE, start=1 at an edge does the following:
    - mcand <= {8'b0, a}
    - mplier <= b
    - acc <= 0
    - count <= 0
    - state <= CALC
    - busy <= 1
    - done <= 0
  - In CALC, start is ignored. Operands presented with it are discarded.
- CALC, at each edge:
  - If mplier[0]=1, acc <= RCA16 sum of acc + mcand, with carryInput=0. Otherwise acc holds.
  - mcand <= mcand << 1 (16-bit, MSB drops).
  - mplier <= mplier >> 1 (zero fill).
  - count <= count + 1.
- Adder usage:
  - The RCA16 instance is always driven with acc and mcand.
  - carryOutput is unused; it is provably 0 for 8x8 unsigned operands.
- Leaving CALC: when count reaches 7 at the edge (the 8th CALC edge):
  - state <= DONE
  - product <= final acc
  - busy <= 0
  - done <= 1
- DONE:
  - done is high for exactly one cycle.
  - At the next edge, state goes to IDLE with done <= 0, unless start=1 (see below).
- Latency: with start sampled at edge 0, done is high between edges 8 and 9. busy is high between edges 0 and 8.
- start=1 in DONE is a back-to-back accept:
  - done drops to 0 and the new operation begins.
  - product keeps the previous result until the new one completes.
- product updates only on the transition into DONE. It is stable at all other times, including during CALC.
- Reset asserted mid-CALC: all state is cleared immediately, without waiting for clk. No partial result is ever presented.

Optional Feature:
- Macro: SHIFT_ADD_MULT8_EARLY_TERM_EN.
- Defined:
  - At any CALC edge where the post-shift mplier (mplier >> 1) equals 0, the block transitions to DONE at that edge, with product <= updated acc.
  - Latency equals the position of the highest set bit of b plus 1, with a minimum of 1 CALC cycle (b=0 gives 1 cycle, b=0x80 gives 8).
  - busy and done timing shift accordingly.
- Undefined: always 8 CALC cycles, regardless of b.

Test Plan:
- a=0xFF, b=0xFF, start pulse at edge 0:
  - product=0xFE01.
  - done high only between edges 8 and 9.
  - busy high for 8 cycles.
- a=0x0D, b=0x0B: product=0x008F.
  - Hold start=1 during the DONE cycle with a=0x80, b=0x02.
  - Second result is 0x0100, done 8 cycles later.
  - product stays 0x008F in between.
- a=0x03, b=0x05 started; start re-asserted at CALC cycle 3 with a=0xFF, b=0xFF:
  - Ignored.
  - product=0x000F at done.
  - No second done follows.
- a=0xAA, b=0x55 started; rst_n driven low midway between edges 4 and 5:
  - product, busy and done go to 0 immediately.
  - After release, a=0x03, b=0x05 gives product=0x000F.
- a=0x00, b=0x5A: product=0x0000 after 8 cycles without the macro.
  - With SHIFT_ADD_MULT8_EARLY_TERM_EN, a=0x5A, b=0x00 gives done after 1 CALC cycle with product=0x0000.
- With SHIFT_ADD_MULT8_EARLY_TERM_EN, a=0x12, b=0x05:
  - product=0x005A.
  - done high between edges 3 and 4.
  - busy low from edge 3.
